// File: rtl/alu_commit_pkg.sv
// rtl/alu_commit_pkg.sv - shared core configuration for the commit stage
// Contents: data/register widths, execution unit count, commit FSM state type.
package alu_commit_pkg;

  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int N_EXEC_UNITS = 4;

  typedef enum logic {
    CM_RUN,
    CM_HALT
  } commit_state_t;

endpackage

// File: rtl/alu_commit_if.sv
// rtl/alu_commit_if.sv - ALU result bus between execution units and commit stage
// Signals (unit i occupies slice i of each vector):
//   u_valid  result valid, held by the unit until it sees u_clear
//   u_res    result data          u_rd    destination register
//   u_error  overflow/illegal     u_req   jump request
//   u_jmp    jump target          u_clear one-cycle clear back to the unit
// Modports: master = execution units, slave = commit stage.
interface alu_commit_if #(
  parameter int N_UNITS    = alu_commit_pkg::N_EXEC_UNITS,
  parameter int XLEN       = alu_commit_pkg::XLEN,
  parameter int REG_ADDR_W = alu_commit_pkg::REG_ADDR_W
);

  logic [N_UNITS-1:0]            u_valid;
  logic [N_UNITS*XLEN-1:0]       u_res;
  logic [N_UNITS*REG_ADDR_W-1:0] u_rd;
  logic [N_UNITS-1:0]            u_error;
  logic [N_UNITS-1:0]            u_req;
  logic [N_UNITS*XLEN-1:0]       u_jmp;
  logic [N_UNITS-1:0]            u_clear;

  modport master (
    output u_valid, u_res, u_rd, u_error, u_req, u_jmp,
    input  u_clear
  );

  modport slave (
    input  u_valid, u_res, u_rd, u_error, u_req, u_jmp,
    output u_clear
  );

endinterface

// File: rtl/alu_commit_rr_arbiter.sv
// rtl/alu_commit_rr_arbiter.sv - combinational round-robin arbiter
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  highest-priority index this cycle
//   grant out N   one-hot grant (zero when no request)
//   idx   out IW  index of the granted request
//   any   out 1   at least one request present
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin : scan
      logic [IW-1:0] j;
      j = IW'((int'(ptr) + k) % N);
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end

endmodule

// File: rtl/alu_commit.sv
// rtl/alu_commit.sv - commit stage: round-robin commit of N execution units
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   units        alu_commit_if.slave result bus (u_clear driven here)
//   wr_en/addr/data   register-file write port (one-cycle strobe)
//   redir_valid/pc    PC redirect (one-cycle strobe)
//   exc_valid/unit    exception pending and faulting unit, held until exc_ack
//   exc_ack           exception acknowledge, only honoured while halted
module alu_commit #(
  parameter int N_UNITS    = alu_commit_pkg::N_EXEC_UNITS,
  parameter int XLEN       = alu_commit_pkg::XLEN,
  parameter int REG_ADDR_W = alu_commit_pkg::REG_ADDR_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  alu_commit_if.slave                units,
  output logic                       wr_en,
  output logic [REG_ADDR_W-1:0]      wr_addr,
  output logic [XLEN-1:0]            wr_data,
  output logic                       redir_valid,
  output logic [XLEN-1:0]            redir_pc,
  output logic                       exc_valid,
  output logic [$clog2(N_UNITS)-1:0] exc_unit,
  input  logic                       exc_ack
);

  import alu_commit_pkg::*;

  localparam int IW = $clog2(N_UNITS);

  commit_state_t state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [N_UNITS-1:0]    clear_q, clear_d;
  logic [N_UNITS-1:0]    elig, grant;
  logic [IW-1:0]         g_idx;
  logic                  g_any;
  logic [XLEN-1:0]       g_res, g_jmp;
  logic [REG_ADDR_W-1:0] g_rd;

  logic                  wr_en_d, redir_valid_d, exc_valid_d;
  logic [REG_ADDR_W-1:0] wr_addr_d;
  logic [XLEN-1:0]       wr_data_d, redir_pc_d;
  logic [IW-1:0]         exc_unit_d;

  // The registered clear doubles as the pending mask: a unit still shows
  // valid during the cycle it is being cleared and must not win again.
  assign units.u_clear = clear_q;
  assign elig          = units.u_valid & ~clear_q;

  rr_arbiter #(.N(N_UNITS), .IW(IW)) u_arb (
    .req   (elig),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (g_idx),
    .any   (g_any)
  );

  assign g_res = units.u_res[int'(g_idx)*XLEN +: XLEN];
  assign g_jmp = units.u_jmp[int'(g_idx)*XLEN +: XLEN];
  assign g_rd  = units.u_rd[int'(g_idx)*REG_ADDR_W +: REG_ADDR_W];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    clear_d       = '0;
    wr_en_d       = 1'b0;
    wr_addr_d     = '0;
    wr_data_d     = '0;
    redir_valid_d = 1'b0;
    redir_pc_d    = '0;
    exc_valid_d   = exc_valid;
    exc_unit_d    = exc_unit;
    case (state_q)
      CM_RUN: begin
        if (g_any) begin
          clear_d = grant;
          ptr_d   = (g_idx == IW'(N_UNITS - 1)) ? '0 : g_idx + 1'b1;
          if (units.u_error[g_idx]) begin
            // Faulting result is dropped; the unit is still freed.
            exc_valid_d = 1'b1;
            exc_unit_d  = g_idx;
            state_d     = CM_HALT;
          end else begin
            wr_en_d   = (g_rd != '0);
            wr_addr_d = g_rd;
            wr_data_d = g_res;
            if (units.u_req[g_idx]) begin
              redir_valid_d = 1'b1;
              redir_pc_d    = g_jmp;
            end
          end
        end
      end
      CM_HALT: begin
        if (exc_ack) begin
          state_d     = CM_RUN;
          exc_valid_d = 1'b0;
          exc_unit_d  = '0;
        end
      end
      default: state_d = CM_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CM_RUN;
      ptr_q       <= '0;
      clear_q     <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
      exc_valid   <= 1'b0;
      exc_unit    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      clear_q     <= clear_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      redir_valid <= redir_valid_d;
      redir_pc    <= redir_pc_d;
      exc_valid   <= exc_valid_d;
      exc_unit    <= exc_unit_d;
    end
  end

endmodule

// File: tb/tb_alu_commit.sv
// tb/tb_alu_commit.sv - self-checking bench for alu_commit
module tb_alu_commit;

  localparam int N  = 4;
  localparam int XL = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en;
  logic [RW-1:0] wr_addr;
  logic [XL-1:0] wr_data;
  logic          redir_valid;
  logic [XL-1:0] redir_pc;
  logic          exc_valid;
  logic [1:0]    exc_unit;
  logic          exc_ack;

  always #5 clk = ~clk;

  alu_commit_if #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) bus ();

  alu_commit #(.N_UNITS(N), .XLEN(XL), .REG_ADDR_W(RW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .units       (bus),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .exc_valid   (exc_valid),
    .exc_unit    (exc_unit),
    .exc_ack     (exc_ack)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input int i, input logic v, input logic [RW-1:0] rd,
                          input logic [XL-1:0] res, input logic req,
                          input logic [XL-1:0] jmp, input logic err);
    bus.u_valid[i]          = v;
    bus.u_rd[i*RW +: RW]    = rd;
    bus.u_res[i*XL +: XL]   = res;
    bus.u_req[i]            = req;
    bus.u_jmp[i*XL +: XL]   = jmp;
    bus.u_error[i]          = err;
  endtask

  typedef struct {
    int          unit;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        req;
    logic [31:0] jmp;
    logic        exp_wr;
    logic        exp_redir;
    logic [3:0]  exp_clear;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // unit, rd, res, req, jmp, exp_wr, exp_redir, exp_clear
    vecs[0] = '{1, 5'd5,  32'hDEAD_BEEF, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0010};
    vecs[1] = '{0, 5'd0,  32'h0000_0007, 1'b1, 32'h0000_0100, 1'b0, 1'b1, 4'b0001};
    vecs[2] = '{2, 5'd1,  32'hFFFF_FFFF, 1'b0, 32'h0,         1'b1, 1'b0, 4'b0100};
    vecs[3] = '{3, 5'd31, 32'h1234_5678, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 4'b1000};

    exc_ack     = 1'b0;
    bus.u_valid = '0;
    bus.u_res   = '0;
    bus.u_rd    = '0;
    bus.u_error = '0;
    bus.u_req   = '0;
    bus.u_jmp   = '0;

    // Reset state
    tick();
    tick();
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    chk("rst.redir_valid", redir_valid, 0);
    chk("rst.redir_pc", redir_pc, 0);
    chk("rst.exc_valid", exc_valid, 0);
    chk("rst.exc_unit", exc_unit, 0);
    chk("rst.u_clear", bus.u_clear, 0);
    rst_n = 1'b1;
    tick();

    // Single-unit commits; valid stays high through the clear cycle.
    for (int v = 0; v < 4; v++) begin
      set_unit(vecs[v].unit, 1'b1, vecs[v].rd, vecs[v].res, vecs[v].req, vecs[v].jmp, 1'b0);
      tick();
      chk($sformatf("v%0d.u_clear", v), bus.u_clear, vecs[v].exp_clear);
      chk($sformatf("v%0d.wr_en", v), wr_en, vecs[v].exp_wr);
      if (vecs[v].exp_wr) begin
        chk($sformatf("v%0d.wr_addr", v), wr_addr, vecs[v].rd);
        chk($sformatf("v%0d.wr_data", v), wr_data, vecs[v].res);
      end
      chk($sformatf("v%0d.redir_valid", v), redir_valid, vecs[v].exp_redir);
      if (vecs[v].exp_redir)
        chk($sformatf("v%0d.redir_pc", v), redir_pc, vecs[v].jmp);
      chk($sformatf("v%0d.exc_valid", v), exc_valid, 0);
      tick();
      chk($sformatf("v%0d.regrant_clear", v), bus.u_clear, 0);
      chk($sformatf("v%0d.regrant_wr", v), wr_en, 0);
      chk($sformatf("v%0d.redir_pulse", v), redir_valid, 0);
      set_unit(vecs[v].unit, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    end

    // All four valid with pointer at 0: strict order 0,1,2,3.
    for (int i = 0; i < N; i++)
      set_unit(i, 1'b1, RW'(10 + i), XL'(32'hA0 + i), 1'b0, '0, 1'b0);
    for (int c = 0; c < N; c++) begin
      tick();
      chk($sformatf("all%0d.u_clear", c), bus.u_clear, 4'b0001 << c);
      chk($sformatf("all%0d.wr_en", c), wr_en, 1);
      chk($sformatf("all%0d.wr_addr", c), wr_addr, 10 + c);
      chk($sformatf("all%0d.wr_data", c), wr_data, 32'hA0 + c);
      if (c > 0) bus.u_valid[c-1] = 1'b0;
    end
    tick();
    bus.u_valid[3] = 1'b0;
    chk("all.idle_clear", bus.u_clear, 0);
    chk("all.idle_wr", wr_en, 0);

    // Pointer wrapped to 0: unit 0 beats unit 3.
    set_unit(0, 1'b1, 5'd20, 32'h20, 1'b0, '0, 1'b0);
    set_unit(3, 1'b1, 5'd23, 32'h23, 1'b0, '0, 1'b0);
    tick();
    chk("wrap.first_clear", bus.u_clear, 4'b0001);
    chk("wrap.first_addr", wr_addr, 20);
    tick();
    bus.u_valid[0] = 1'b0;
    chk("wrap.second_clear", bus.u_clear, 4'b1000);
    chk("wrap.second_addr", wr_addr, 23);
    tick();
    bus.u_valid[3] = 1'b0;
    chk("wrap.idle_clear", bus.u_clear, 0);

    // Error on unit 2 while unit 3 waits.
    set_unit(2, 1'b1, 5'd7, 32'h77, 1'b1, 32'h200, 1'b1);
    set_unit(3, 1'b1, 5'd9, 32'h33, 1'b0, '0, 1'b0);
    tick();
    chk("err.exc_valid", exc_valid, 1);
    chk("err.exc_unit", exc_unit, 2);
    chk("err.u_clear", bus.u_clear, 4'b0100);
    chk("err.wr_en", wr_en, 0);
    chk("err.redir_valid", redir_valid, 0);
    tick();
    chk("halt.exc_held", exc_valid, 1);
    chk("halt.u_clear", bus.u_clear, 0);
    chk("halt.wr_en", wr_en, 0);
    set_unit(2, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    chk("halt2.exc_held", exc_valid, 1);
    chk("halt2.exc_unit", exc_unit, 2);
    chk("halt2.u_clear", bus.u_clear, 0);
    exc_ack = 1'b1;
    tick();
    exc_ack = 1'b0;
    chk("ack.exc_valid", exc_valid, 0);
    chk("ack.wr_en", wr_en, 0);
    tick();
    chk("resume.u_clear", bus.u_clear, 4'b1000);
    chk("resume.wr_en", wr_en, 1);
    chk("resume.wr_addr", wr_addr, 9);
    chk("resume.wr_data", wr_data, 32'h33);
    tick();
    bus.u_valid[3] = 1'b0;

    // Asynchronous reset while halted with a clear pending.
    set_unit(1, 1'b1, 5'd4, 32'h55, 1'b0, '0, 1'b1);
    tick();
    chk("pre_rst.exc_valid", exc_valid, 1);
    chk("pre_rst.u_clear", bus.u_clear, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.exc_valid", exc_valid, 0);
    chk("async_rst.exc_unit", exc_unit, 0);
    chk("async_rst.u_clear", bus.u_clear, 0);
    chk("async_rst.wr_en", wr_en, 0);
    set_unit(1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    tick();
    rst_n = 1'b1;
    set_unit(0, 1'b1, 5'd2, 32'hC0, 1'b0, '0, 1'b0);
    set_unit(2, 1'b1, 5'd6, 32'hC2, 1'b0, '0, 1'b0);
    tick();
    chk("post_rst.u_clear", bus.u_clear, 4'b0001);
    chk("post_rst.wr_addr", wr_addr, 2);
    tick();
    bus.u_valid[0] = 1'b0;
    chk("post_rst2.u_clear", bus.u_clear, 4'b0100);
    chk("post_rst2.wr_data", wr_data, 32'hC2);
    tick();
    bus.u_valid[2] = 1'b0;
    chk("post_rst.idle", bus.u_clear, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
